// File: rtl/countdown_timer.sv
// MM:SS countdown timer with edge-detected set/start/clear requests and BCD digit outputs.
// Four-state control (IDLE, RUN, PAUSE, EXPIRED); one decrement every TICK_DIV clocks while running.
module countdown_timer #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic       CLK100MHZ,
    input  logic       RESET_BTN,
    input  logic       START_STOP,
    input  logic       CLEAR,
    input  logic       INC_MIN,
    input  logic       INC_SEC,
    output logic [3:0] mins2,
    output logic [3:0] mins1,
    output logic [3:0] secs2,
    output logic [3:0] secs1,
    output logic       RUNNING,
    output logic       DONE
);

    localparam int unsigned       TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    // Step a two-digit BCD value through 00..59, wrapping to 00.
    function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = v[7:4];
        ones = v[3:0];
        if (ones >= 4'd9) begin
            ones = 4'd0;
            tens = (tens >= 4'd5) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    // One-second decrement of MM:SS with BCD borrows; callers never pass 00:00.
    function automatic logic [15:0] dec_time(input logic [15:0] t);
        logic [3:0] m2;
        logic [3:0] m1;
        logic [3:0] s2;
        logic [3:0] s1;
        {m2, m1, s2, s1} = t;
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s2 != 4'd0) begin
                s2 = s2 - 4'd1;
            end else begin
                s2 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1 = 4'd9;
                    m2 = (m2 != 4'd0) ? m2 - 4'd1 : 4'd0;
                end
            end
        end
        return {m2, m1, s2, s1};
    endfunction

    state_t            r_state;
    logic [TICK_W-1:0] r_tick;
    logic [3:0]        r_mins2;
    logic [3:0]        r_mins1;
    logic [3:0]        r_secs2;
    logic [3:0]        r_secs1;
    logic              r_running;
    logic              r_done;
    logic              r_ss_q;
    logic              r_clr_q;
    logic              r_min_q;
    logic              r_sec_q;

    logic              w_ss_edge;
    logic              w_clr_edge;
    logic              w_min_edge;
    logic              w_sec_edge;
    logic [15:0]       w_time;
    logic [15:0]       w_time_dec;
    logic [7:0]        w_min_inc;
    logic [7:0]        w_sec_inc;
    logic              w_tick_last;

    assign w_ss_edge   = START_STOP & ~r_ss_q;
    assign w_clr_edge  = CLEAR      & ~r_clr_q;
    assign w_min_edge  = INC_MIN    & ~r_min_q;
    assign w_sec_edge  = INC_SEC    & ~r_sec_q;

    assign w_time      = {r_mins2, r_mins1, r_secs2, r_secs1};
    assign w_time_dec  = dec_time(w_time);
    assign w_min_inc   = inc_bcd60({r_mins2, r_mins1});
    assign w_sec_inc   = inc_bcd60({r_secs2, r_secs1});
    assign w_tick_last = (r_tick == TICK_LAST);

    always_ff @(posedge CLK100MHZ or negedge RESET_BTN) begin
        if (!RESET_BTN) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_mins2   <= 4'd0;
            r_mins1   <= 4'd0;
            r_secs2   <= 4'd0;
            r_secs1   <= 4'd0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_ss_q    <= 1'b0;
            r_clr_q   <= 1'b0;
            r_min_q   <= 1'b0;
            r_sec_q   <= 1'b0;
        end else begin
            r_ss_q  <= START_STOP;
            r_clr_q <= CLEAR;
            r_min_q <= INC_MIN;
            r_sec_q <= INC_SEC;

            if (w_clr_edge) begin
                r_state   <= S_IDLE;
                r_tick    <= '0;
                r_mins2   <= 4'd0;
                r_mins1   <= 4'd0;
                r_secs2   <= 4'd0;
                r_secs1   <= 4'd0;
                r_running <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tick <= '0;
                        if (w_min_edge) begin
                            {r_mins2, r_mins1} <= w_min_inc;
                        end
                        if (w_sec_edge) begin
                            {r_secs2, r_secs1} <= w_sec_inc;
                        end
                        if (w_ss_edge && (w_time != 16'h0000)) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end

                    S_RUN: begin
                        // A terminal tick always decrements, even when a pause arrives with it.
                        if (w_tick_last) begin
                            r_tick <= '0;
                            {r_mins2, r_mins1, r_secs2, r_secs1} <= w_time_dec;
                            if (w_time_dec == 16'h0000) begin
                                r_state   <= S_EXPIRED;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
                            end else if (w_ss_edge) begin
                                r_state   <= S_PAUSE;
                                r_running <= 1'b0;
                            end
                        end else if (w_ss_edge) begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                        end else begin
                            r_tick <= r_tick + TICK_W'(1);
                        end
                    end

                    S_PAUSE: begin
                        if (w_ss_edge) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end

                    S_EXPIRED: begin
                        r_tick  <= '0;
                        r_mins2 <= 4'd0;
                        r_mins1 <= 4'd0;
                        r_secs2 <= 4'd0;
                        r_secs1 <= 4'd0;
                        if (w_ss_edge) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b0;
                        end
                    end

                    default: begin
                        r_state   <= S_IDLE;
                        r_tick    <= '0;
                        r_running <= 1'b0;
                        r_done    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mins2   = r_mins2;
    assign mins1   = r_mins1;
    assign secs2   = r_secs2;
    assign secs1   = r_secs1;
    assign RUNNING = r_running;
    assign DONE    = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Scenario bench for countdown_timer at TICK_DIV=10: expected {RUNNING,DONE,MM:SS} snapshots go through a queue.
module tb_countdown_timer;

    localparam int unsigned TICK_DIV = 10;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss    = 1'b0;
    logic       clr   = 1'b0;
    logic       imin  = 1'b0;
    logic       isec  = 1'b0;
    logic [3:0] mins2;
    logic [3:0] mins1;
    logic [3:0] secs2;
    logic [3:0] secs1;
    logic       running;
    logic       done;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] sb[$];
    logic [17:0] exp_v;

    always #5 clk = ~clk;

    countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
        .CLK100MHZ (clk),
        .RESET_BTN (rst_n),
        .START_STOP(ss),
        .CLEAR     (clr),
        .INC_MIN   (imin),
        .INC_SEC   (isec),
        .mins2     (mins2),
        .mins1     (mins1),
        .secs2     (secs2),
        .secs1     (secs1),
        .RUNNING   (running),
        .DONE      (done)
    );

    function automatic logic [17:0] obs();
        return {running, done, mins2, mins1, secs2, secs1};
    endfunction

    function automatic logic [17:0] mk(input logic r, input logic d, input logic [15:0] t);
        return {r, d, t};
    endfunction

    // Called at a negedge: inputs high for one clock edge, low for the next; returns at a negedge.
    task automatic pulse(input logic [3:0] m);
        {ss, clr, imin, isec} = m;
        @(negedge clk);
        {ss, clr, imin, isec} = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset();
        sb.push_back(mk(1'b0, 1'b0, 16'h0000));
        #1;
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL reset_init got %h exp %h", obs(), exp_v); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) pulse(4'b0010);
        sb.push_back(mk(1'b0, 1'b0, 16'h0300));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL reset_set0300 got %h exp %h", obs(), exp_v); end
        pulse(4'b1000);
        repeat (3) @(negedge clk);
        sb.push_back(mk(1'b1, 1'b0, 16'h0300));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL reset_running got %h exp %h", obs(), exp_v); end
        sb.push_back(mk(1'b0, 1'b0, 16'h0000));
        #2 rst_n = 1'b0;
        #1;
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL reset_async got %h exp %h", obs(), exp_v); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_countdown();
        pulse(4'b0010);
        for (int i = 0; i < 5; i++) pulse(4'b0001);
        sb.push_back(mk(1'b0, 1'b0, 16'h0105));
        sb.push_back(mk(1'b1, 1'b0, 16'h0105));
        sb.push_back(mk(1'b1, 1'b0, 16'h0104));
        sb.push_back(mk(1'b1, 1'b0, 16'h0100));
        sb.push_back(mk(1'b1, 1'b0, 16'h0059));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL cd_set got %h exp %h", obs(), exp_v); end
        pulse(4'b1000);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL cd_start got %h exp %h", obs(), exp_v); end
        repeat (9) @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL cd_10 got %h exp %h", obs(), exp_v); end
        repeat (40) @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL cd_50 got %h exp %h", obs(), exp_v); end
        repeat (10) @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL cd_60_borrow got %h exp %h", obs(), exp_v); end
        pulse(4'b0100);
        sb.push_back(mk(1'b0, 1'b0, 16'h0000));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL cd_clear got %h exp %h", obs(), exp_v); end
    endtask

    task automatic test_expiry();
        pulse(4'b0001);
        pulse(4'b0001);
        pulse(4'b1000);
        sb.push_back(mk(1'b1, 1'b0, 16'h0001));
        sb.push_back(mk(1'b0, 1'b1, 16'h0000));
        sb.push_back(mk(1'b0, 1'b1, 16'h0000));
        sb.push_back(mk(1'b0, 1'b0, 16'h0000));
        repeat (18) @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL exp_19 got %h exp %h", obs(), exp_v); end
        @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL exp_done got %h exp %h", obs(), exp_v); end
        repeat (100) @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL exp_hold got %h exp %h", obs(), exp_v); end
        pulse(4'b1000);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL exp_to_idle got %h exp %h", obs(), exp_v); end
    endtask

    task automatic test_pause();
        for (int i = 0; i < 5; i++) pulse(4'b0001);
        pulse(4'b1000);
        repeat (3) @(negedge clk);
        pulse(4'b1000);
        sb.push_back(mk(1'b0, 1'b0, 16'h0005));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL pause_enter got %h exp %h", obs(), exp_v); end
        sb.push_back(mk(1'b0, 1'b0, 16'h0005));
        repeat (100) @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL pause_frozen got %h exp %h", obs(), exp_v); end
        pulse(4'b1000);
        sb.push_back(mk(1'b1, 1'b0, 16'h0005));
        sb.push_back(mk(1'b1, 1'b0, 16'h0005));
        sb.push_back(mk(1'b1, 1'b0, 16'h0004));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL pause_resume got %h exp %h", obs(), exp_v); end
        repeat (4) @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL pause_5after got %h exp %h", obs(), exp_v); end
        @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL pause_6after got %h exp %h", obs(), exp_v); end
        repeat (9) @(negedge clk);
        pulse(4'b1000);
        sb.push_back(mk(1'b0, 1'b0, 16'h0003));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL pause_on_terminal got %h exp %h", obs(), exp_v); end
        pulse(4'b1000);
        repeat (9) @(negedge clk);
        sb.push_back(mk(1'b1, 1'b0, 16'h0002));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL pause_full_period got %h exp %h", obs(), exp_v); end
        pulse(4'b0100);
    endtask

    task automatic test_wrap_ignore();
        for (int i = 0; i < 59; i++) pulse(4'b0001);
        sb.push_back(mk(1'b0, 1'b0, 16'h0059));
        sb.push_back(mk(1'b0, 1'b0, 16'h0000));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL wrap_sec59 got %h exp %h", obs(), exp_v); end
        pulse(4'b0001);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL wrap_sec60 got %h exp %h", obs(), exp_v); end
        for (int i = 0; i < 59; i++) pulse(4'b0010);
        sb.push_back(mk(1'b0, 1'b0, 16'h5900));
        sb.push_back(mk(1'b0, 1'b0, 16'h0100));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL wrap_min59 got %h exp %h", obs(), exp_v); end
        pulse(4'b0010);
        pulse(4'b0010);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL wrap_min61 got %h exp %h", obs(), exp_v); end
        pulse(4'b0100);
        pulse(4'b1000);
        sb.push_back(mk(1'b0, 1'b0, 16'h0000));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL start_at_zero got %h exp %h", obs(), exp_v); end
        pulse(4'b0011);
        sb.push_back(mk(1'b0, 1'b0, 16'h0101));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL inc_both got %h exp %h", obs(), exp_v); end
        pulse(4'b1000);
        pulse(4'b0011);
        sb.push_back(mk(1'b1, 1'b0, 16'h0101));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL inc_in_run got %h exp %h", obs(), exp_v); end
        pulse(4'b0100);
    endtask

    task automatic test_priority();
        for (int i = 0; i < 3; i++) pulse(4'b0001);
        pulse(4'b1000);
        repeat (2) @(negedge clk);
        sb.push_back(mk(1'b0, 1'b0, 16'h0000));
        ss  = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL clr_over_start got %h exp %h", obs(), exp_v); end
        ss  = 1'b0;
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        pulse(4'b0001);
        rst_n = 1'b0;
        isec  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(1'b0, 1'b0, 16'h0001));
        sb.push_back(mk(1'b0, 1'b0, 16'h0001));
        @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL edge_after_reset got %h exp %h", obs(), exp_v); end
        repeat (20) @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL held_once got %h exp %h", obs(), exp_v); end
        isec = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) pulse(4'b0001);
        sb.push_back(mk(1'b0, 1'b0, 16'h0005));
        exp_v = sb.pop_front(); checks++;
        if (obs() !== exp_v) begin errors++; $display("FAIL back_to_back got %h exp %h", obs(), exp_v); end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_expiry();
        test_pause();
        test_wrap_ignore();
        test_priority();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
